// File: rtl/sram_port_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port SRAM with one-cycle registered read.
// Define SRAM_ARB_RR_EN for round-robin contention; default build gives writes fixed priority.
module sram_port_arbiter #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  inst_clk,
   input  logic                  inst_rst_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   input  logic                  cnt_clr,
   output logic [CNT_WIDTH-1:0]  wr_cnt,
   output logic [CNT_WIDTH-1:0]  rd_cnt,
   output logic                  sram_cs_n,
   output logic                  sram_wr_n,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;

   logic rd_slot_free;
   logic wr_req;
   logic rd_req;
   logic wr_win;
   logic rd_win;

`ifdef SRAM_ARB_RR_EN
   // Pointer 0 favours the write port on the next contended cycle.
   logic rr_ptr_q, rr_ptr_d;
`endif

   // Grant decision: reset forces both requesters off the port.
   always_comb begin
      rd_slot_free = (state_q == ST_IDLE) || rsp_ready;
      wr_req       = wr_valid && inst_rst_n;
      rd_req       = rd_valid && rd_slot_free && inst_rst_n;
`ifdef SRAM_ARB_RR_EN
      wr_win       = wr_req && (!rd_req || !rr_ptr_q);
`else
      wr_win       = wr_req;
`endif
      rd_win       = rd_req && !wr_win;
   end

   // Next-state for response tracking, counters and round-robin pointer.
   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
`ifdef SRAM_ARB_RR_EN
      rr_ptr_d = rr_ptr_q;
      if (wr_req && rd_req) begin
         rr_ptr_d = !rr_ptr_q;
      end
`endif
      case (state_q)
         ST_IDLE: begin
            if (rd_win) begin
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            if (rsp_ready && !rd_win) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (cnt_clr) begin
         wr_cnt_d = '0;
         rd_cnt_d = '0;
      end else begin
         if (wr_win) begin
            wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
         end
         if (rd_win) begin
            rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge inst_clk or negedge inst_rst_n) begin
      if (!inst_rst_n) begin
         state_q  <= ST_IDLE;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
`ifdef SRAM_ARB_RR_EN
         rr_ptr_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
`ifdef SRAM_ARB_RR_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   // The SRAM output register only changes on a read, so it doubles as the response buffer.
   assign wr_ready  = wr_win;
   assign rd_ready  = rd_win;
   assign sram_cs_n = !(wr_win || rd_win);
   assign sram_wr_n = !wr_win;
   assign sram_addr = rd_win ? rd_addr : wr_addr;
   assign sram_din  = wr_data;
   assign rsp_valid = (state_q == ST_PEND);
   assign rsp_data  = sram_dout;
   assign wr_cnt    = wr_cnt_q;
   assign rd_cnt    = rd_cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: behavioural SRAM, queue-based reference model,
// directed cases from the plan plus hold-stable randomized traffic.
module tb_sram_port_arbiter;

   localparam int unsigned DW = 512;
   localparam int unsigned AW = 6;
   localparam int unsigned CW = 16;

   logic          inst_clk = 1'b0;
   logic          inst_rst_n;
   logic          wr_valid, wr_ready, rd_valid, rd_ready;
   logic [AW-1:0] wr_addr, rd_addr, sram_addr;
   logic [DW-1:0] wr_data, rsp_data, sram_din, sram_dout;
   logic          rsp_valid, rsp_ready, cnt_clr;
   logic [CW-1:0] wr_cnt, rd_cnt;
   logic          sram_cs_n, sram_wr_n;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 inst_clk = !inst_clk;

   sram_port_arbiter dut (
      .inst_clk  (inst_clk),
      .inst_rst_n(inst_rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_addr   (rd_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .cnt_clr   (cnt_clr),
      .wr_cnt    (wr_cnt),
      .rd_cnt    (rd_cnt),
      .sram_cs_n (sram_cs_n),
      .sram_wr_n (sram_wr_n),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_dout (sram_dout)
   );

   // Behavioural single-port SRAM with registered read.
   logic [DW-1:0] sram_mem [64];
   initial begin
      for (int i = 0; i < 64; i++) sram_mem[i] = '0;
      sram_dout = '0;
   end
   always @(posedge inst_clk) begin
      if (!sram_cs_n) begin
         if (!sram_wr_n) sram_mem[sram_addr] <= sram_din;
         else            sram_dout <= sram_mem[sram_addr];
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: memory image, queue of owed responses, counters, contention pointer.
   logic [DW-1:0] m_mem [64];
   logic [DW-1:0] m_rsp [$];
   int unsigned   m_wr_cnt, m_rd_cnt;
   bit            m_favour_rd;
   initial begin
      for (int i = 0; i < 64; i++) m_mem[i] = '0;
      m_wr_cnt = 0; m_rd_cnt = 0; m_favour_rd = 1'b0;
   end

   always @(negedge inst_clk) begin
      bit slot_free, want_w, want_r, exp_w, exp_r;
      if (!inst_rst_n) begin
         chk("m_rst_cs_n", DW'(sram_cs_n), DW'(1));
         chk("m_rst_wr_n", DW'(sram_wr_n), DW'(1));
         chk("m_rst_wr_ready", DW'(wr_ready), DW'(0));
         chk("m_rst_rd_ready", DW'(rd_ready), DW'(0));
         chk("m_rst_rsp_valid", DW'(rsp_valid), DW'(0));
         m_rsp.delete();
         m_wr_cnt = 0; m_rd_cnt = 0; m_favour_rd = 1'b0;
      end else begin
         chk("m_rsp_valid", DW'(rsp_valid), DW'(m_rsp.size() != 0));
         if (m_rsp.size() != 0) chk("m_rsp_data", rsp_data, m_rsp[0]);
         chk("m_wr_cnt", DW'(wr_cnt), DW'(m_wr_cnt % 65536));
         chk("m_rd_cnt", DW'(rd_cnt), DW'(m_rd_cnt % 65536));
         slot_free = (m_rsp.size() == 0) || rsp_ready;
         want_w = wr_valid;
         want_r = rd_valid && slot_free;
`ifdef SRAM_ARB_RR_EN
         exp_w = want_w && (!want_r || !m_favour_rd);
`else
         exp_w = want_w;
`endif
         exp_r = want_r && !exp_w;
         chk("m_wr_ready", DW'(wr_ready), DW'(exp_w));
         chk("m_rd_ready", DW'(rd_ready), DW'(exp_r));
         chk("m_cs_n", DW'(sram_cs_n), DW'(!(exp_w || exp_r)));
         if (exp_w) begin
            chk("m_wr_n_w", DW'(sram_wr_n), DW'(0));
            chk("m_addr_w", DW'(sram_addr), DW'(wr_addr));
            chk("m_din_w", sram_din, wr_data);
         end
         if (exp_r) begin
            chk("m_wr_n_r", DW'(sram_wr_n), DW'(1));
            chk("m_addr_r", DW'(sram_addr), DW'(rd_addr));
         end
         if (rsp_ready && m_rsp.size() != 0) void'(m_rsp.pop_front());
         if (exp_r) m_rsp.push_back(m_mem[rd_addr]);
         if (exp_w) m_mem[wr_addr] = wr_data;
`ifdef SRAM_ARB_RR_EN
         if (want_w && want_r) m_favour_rd = !m_favour_rd;
`endif
         if (cnt_clr) begin
            m_wr_cnt = 0; m_rd_cnt = 0;
         end else begin
            if (exp_w) m_wr_cnt++;
            if (exp_r) m_rd_cnt++;
         end
      end
   end

   task automatic cyc();
      @(posedge inst_clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
      return w;
   endfunction

   logic [DW-1:0] a5_word;
   logic [3:0]    grants, exp_grants;
   logic [CW-1:0] rd_cnt_before;
   int unsigned   exp_rd_delta;

   initial begin
      a5_word = {64{8'hA5}};
      inst_rst_n = 1'b0;
      wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b0; cnt_clr = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;

      // Reset with both requesters asserting.
      repeat (3) cyc();
      chk("rst_cs_n", DW'(sram_cs_n), DW'(1));
      chk("rst_wr_ready", DW'(wr_ready), DW'(0));
      chk("rst_rd_ready", DW'(rd_ready), DW'(0));
      chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
      chk("rst_wr_cnt", DW'(wr_cnt), DW'(0));
      chk("rst_rd_cnt", DW'(rd_cnt), DW'(0));
      wr_valid = 1'b0; rd_valid = 1'b0;
      inst_rst_n = 1'b1;

      // Write A5.. to addr 5, read it next cycle, then stall the response.
      wr_valid = 1'b1; wr_addr = 6'd5; wr_data = a5_word;
      #1 chk("w5_ready", DW'(wr_ready), DW'(1));
      cyc();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd5; rsp_ready = 1'b0;
      #1 chk("r5_ready", DW'(rd_ready), DW'(1));
      chk("w5_cnt", DW'(wr_cnt), DW'(1));
      cyc();
      rd_addr = 6'd6;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("r5_rsp_valid", DW'(rsp_valid), DW'(1));
         chk("r5_rsp_data", rsp_data, a5_word);
         chk("r6_stalled", DW'(rd_ready), DW'(0));
         chk("r5_rd_cnt", DW'(rd_cnt), DW'(1));
         cyc();
      end
      rsp_ready = 1'b1;
      #1 chk("r6_granted", DW'(rd_ready), DW'(1));
      cyc();
      rd_valid = 1'b0;
      #1 chk("r6_rsp_valid", DW'(rsp_valid), DW'(1));
      chk("r6_rd_cnt", DW'(rd_cnt), DW'(2));
      cyc();
      #1 chk("r6_drained", DW'(rsp_valid), DW'(0));

      // Contention for four cycles.
      rd_cnt_before = rd_cnt;
      wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
      grants = '0;
      for (int i = 3; i >= 0; i--) begin
         wr_addr = 6'(40 + i); wr_data = rand_word(); rd_addr = 6'(i);
         #1 grants[i] = wr_ready;
         cyc();
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
`ifdef SRAM_ARB_RR_EN
      exp_grants = 4'b1010; exp_rd_delta = 2;
`else
      exp_grants = 4'b1111; exp_rd_delta = 0;
`endif
      chk("contention_grants", DW'(grants), DW'(exp_grants));
      chk("contention_rd_cnt", DW'(rd_cnt - rd_cnt_before), DW'(exp_rd_delta));
      cyc();

      // Clear, then 64 back-to-back writes and 64 back-to-back reads.
      cnt_clr = 1'b1;
      cyc();
      cnt_clr = 1'b0;
      #1 chk("clr_wr_cnt", DW'(wr_cnt), DW'(0));
      chk("clr_rd_cnt", DW'(rd_cnt), DW'(0));
      for (int i = 0; i < 64; i++) begin
         wr_valid = 1'b1; wr_addr = 6'(i); wr_data = DW'(i);
         cyc();
      end
      wr_valid = 1'b0;
      rd_valid = 1'b1; rd_addr = 6'd0;
      for (int i = 0; i < 64; i++) begin
         cyc();
         if (i < 63) rd_addr = 6'(i + 1);
         else        rd_valid = 1'b0;
         #1 chk("seq_rsp_valid", DW'(rsp_valid), DW'(1));
         chk("seq_rsp_data", rsp_data, DW'(i));
      end
      chk("seq_wr_cnt", DW'(wr_cnt), DW'(64));
      chk("seq_rd_cnt", DW'(rd_cnt), DW'(64));
      cyc();

      // Clear coincident with a write grant.
      wr_valid = 1'b1; wr_addr = 6'd0; wr_data = DW'(0); cnt_clr = 1'b1;
      #1 chk("clr_grant_ready", DW'(wr_ready), DW'(1));
      cyc();
      wr_valid = 1'b0; cnt_clr = 1'b0;
      #1 chk("clr_grant_wr_cnt", DW'(wr_cnt), DW'(0));

      // Reset asserted while a response is pending.
      rd_valid = 1'b1; rd_addr = 6'd3; rsp_ready = 1'b0;
      cyc();
      rd_valid = 1'b0;
      #1 chk("pend_before_rst", DW'(rsp_valid), DW'(1));
      wr_valid = 1'b1; rd_valid = 1'b1;
      #1 inst_rst_n = 1'b0;
      #1 chk("pend_rst_rsp_valid", DW'(rsp_valid), DW'(0));
      chk("pend_rst_wr_cnt", DW'(wr_cnt), DW'(0));
      chk("pend_rst_rd_cnt", DW'(rd_cnt), DW'(0));
      chk("pend_rst_cs_n", DW'(sram_cs_n), DW'(1));
      chk("pend_rst_wr_ready", DW'(wr_ready), DW'(0));
      cyc(); cyc();
      wr_valid = 1'b0; rd_valid = 1'b0;
      inst_rst_n = 1'b1;

      // Randomized traffic; requesters hold address/data until granted.
      for (int n = 0; n < 3000; n++) begin
         bit wf, rf;
         @(negedge inst_clk);
         wf = wr_valid && wr_ready;
         rf = rd_valid && rd_ready;
         cyc();
         if (!wr_valid || wf) begin
            wr_valid = ($urandom_range(0, 99) < 40);
            wr_addr  = 6'($urandom_range(0, 63));
            wr_data  = rand_word();
         end
         if (!rd_valid || rf) begin
            rd_valid = ($urandom_range(0, 99) < 60);
            rd_addr  = 6'($urandom_range(0, 63));
         end
         rsp_ready = ($urandom_range(0, 99) < 70);
         cnt_clr   = ($urandom_range(0, 49) == 0);
      end
      wr_valid = 1'b0; rd_valid = 1'b0; cnt_clr = 1'b0; rsp_ready = 1'b1;
      repeat (3) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
